// File: rtl/package_settings.sv
`default_nettype none
// ============================================================================
//  Module   : package_settings
//  Purpose  : Shared front-end settings. Holds the filter data width used by
//             the shaping filter and everything downstream of it.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package package_settings;

    // Magnitude bits of the shaping filter output; the sample carries one
    // extra sign bit on top of this.
    localparam int SIZE_FILTER_DATA = 20;

endpackage : package_settings
`default_nettype wire

// File: rtl/pulse_event_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_event_pkg
//  Purpose  : Types and default constants for the pulse event sequencer:
//             FSM state encoding, event record layout, default sizes.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pulse_event_pkg;

    import package_settings::*;

    // Default sizes
    localparam int DATA_W_DEF   = SIZE_FILTER_DATA + 1;
    localparam int TS_W_DEF     = 32;
    localparam int PEAK_WIN_DEF = 32;
    localparam int HOLDOFF_DEF  = 16;
    localparam int DROP_W_DEF   = 16;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_HOLD = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    // Event record at default widths. The flat record in the top level uses
    // the same field order: {amp, ts, pileup, timeout}.
    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] amp;
        logic        [TS_W_DEF-1:0]   ts;
        logic                         pileup;
        logic                         timeout;
    } ev_rec_t;

endpackage : pulse_event_pkg
`default_nettype wire

// File: rtl/pulse_event_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_event_ctrl_if
//  Purpose  : Event record valid/ready channel between the pulse event
//             sequencer (master) and the readout/DAQ consumer (slave).
//  Signals  : ev_valid   - record available (master -> slave)
//             ev_ready   - consumer accepts record (slave -> master)
//             ev_amp     - peak amplitude, signed
//             ev_ts      - timestamp of threshold crossing
//             ev_pileup  - retrigger occurred during hold-off
//             ev_timeout - peak not found inside the search window
//  Revision : 1.0 - initial release
// ============================================================================
interface pulse_event_ctrl_if
    import pulse_event_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TS_W   = TS_W_DEF
) ();

    logic                     ev_valid;
    logic                     ev_ready;
    logic signed [DATA_W-1:0] ev_amp;
    logic        [TS_W-1:0]   ev_ts;
    logic                     ev_pileup;
    logic                     ev_timeout;

    modport master (
        output ev_valid, ev_amp, ev_ts, ev_pileup, ev_timeout,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_amp, ev_ts, ev_pileup, ev_timeout,
        output ev_ready
    );

endinterface : pulse_event_ctrl_if
`default_nettype wire

// File: rtl/event_out_reg.sv
`default_nettype none
// ============================================================================
//  Module   : event_out_reg
//  Purpose  : One-deep valid/ready holding register for event records plus a
//             saturating counter of records lost because the register was
//             still occupied when a new one arrived.
//  Ports    : clk, reset (sync, active-low)
//             load     - a finished record is offered this cycle
//             load_rec - the offered record
//             ready    - consumer accepts the held record
//             valid    - held record is valid
//             rec      - held record
//             drop_cnt - lost-record count, sticks at all-ones
//  Revision : 1.0 - initial release
// ============================================================================
module event_out_reg #(
    parameter int REC_W  = 55,
    parameter int DROP_W = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              load,
    input  wire logic [REC_W-1:0]  load_rec,
    input  wire logic              ready,
    output logic                   valid,
    output logic      [REC_W-1:0]  rec,
    output logic      [DROP_W-1:0] drop_cnt
);

    logic              r_valid;
    logic [REC_W-1:0]  r_rec;
    logic [DROP_W-1:0] r_drop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_rec   <= '0;
            r_drop  <= '0;
        end else begin
            if (load && (!r_valid || ready)) begin
                // Empty, or the held record leaves this same cycle: the new
                // record takes its place and valid stays asserted.
                r_valid <= 1'b1;
                r_rec   <= load_rec;
            end else begin
                if (r_valid && ready) begin
                    r_valid <= 1'b0;
                end
                // Reaching here with load set means the register is full
                // and not being drained, so the offered record is lost.
                if (load && (r_drop != '1)) begin
                    r_drop <= r_drop + DROP_W'(1);
                end
            end
        end
    end

    assign valid    = r_valid;
    assign rec      = r_rec;
    assign drop_cnt = r_drop;

endmodule : event_out_reg
`default_nettype wire

// File: rtl/pulse_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_event_ctrl
//  Purpose  : Pulse event sequencer behind the shaping filter. Arms on a
//             threshold crossing, finds the pulse peak, waits out a hold-off
//             (flagging pile-up) and hands one record per pulse to the
//             readout through a one-deep valid/ready register.
//  Ports    : clk, reset (sync, active-low)
//             en        - acquisition enable
//             filt_data - signed filter output, one sample per clk
//             threshold - signed trigger level
//             ev        - event record channel (master side)
//             drop_cnt  - records lost to a full output register, saturating
//             busy      - sequencer not idle
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_event_ctrl
    import pulse_event_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TS_W     = TS_W_DEF,
    parameter int PEAK_WIN = PEAK_WIN_DEF,
    parameter int HOLDOFF  = HOLDOFF_DEF,
    parameter int DROP_W   = DROP_W_DEF
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     en,
    input  wire logic signed [DATA_W-1:0] filt_data,
    input  wire logic signed [DATA_W-1:0] threshold,
    pulse_event_ctrl_if.master            ev,
    output logic             [DROP_W-1:0] drop_cnt,
    output logic                          busy
);

    localparam int REC_W = DATA_W + TS_W + 2;
    // win_cnt never needs to hold more than PEAK_WIN-1.
    localparam int WIN_W = (PEAK_WIN > 2) ? $clog2(PEAK_WIN) : 1;
    localparam int HO_W  = $clog2(HOLDOFF + 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                   r_state,   state_n;
    logic        [TS_W-1:0]   r_ts_cnt;
    logic        [TS_W-1:0]   r_ts,      ts_n;
    logic signed [DATA_W-1:0] r_max,     max_n;
    logic signed [DATA_W-1:0] r_amp,     amp_n;
    logic        [WIN_W-1:0]  r_win_cnt, win_n;
    logic        [HO_W-1:0]   r_ho_cnt,  ho_n;
    logic                     r_pileup,  pile_n;
    logic                     r_timeout, tmo_n;

    logic                     w_emit;
    logic                     w_above;
    logic        [HO_W-1:0]   w_ho_inc;
    logic        [REC_W-1:0]  w_load_rec;
    logic        [REC_W-1:0]  w_rec;

    assign w_above  = (filt_data > threshold);
    assign w_ho_inc = r_ho_cnt + HO_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ts_cnt  <= '0;
            r_ts      <= '0;
            r_max     <= '0;
            r_amp     <= '0;
            r_win_cnt <= '0;
            r_ho_cnt  <= '0;
            r_pileup  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= state_n;
            r_ts_cnt  <= r_ts_cnt + TS_W'(1);
            r_ts      <= ts_n;
            r_max     <= max_n;
            r_amp     <= amp_n;
            r_win_cnt <= win_n;
            r_ho_cnt  <= ho_n;
            r_pileup  <= pile_n;
            r_timeout <= tmo_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_n = r_state;
        ts_n    = r_ts;
        max_n   = r_max;
        amp_n   = r_amp;
        win_n   = r_win_cnt;
        ho_n    = r_ho_cnt;
        pile_n  = r_pileup;
        tmo_n   = r_timeout;
        w_emit  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (en && w_above) begin
                    state_n = ST_RISE;
                    ts_n    = r_ts_cnt;
                    max_n   = filt_data;
                    win_n   = '0;
                    ho_n    = '0;
                    pile_n  = 1'b0;
                    tmo_n   = 1'b0;
                end
            end

            ST_RISE: begin
                if (!en) begin
                    state_n = ST_IDLE;
                end else if (filt_data < r_max) begin
                    amp_n   = r_max;
                    ho_n    = '0;
                    state_n = ST_HOLD;
                end else begin
                    max_n = filt_data;
                    win_n = r_win_cnt + WIN_W'(1);
                    // The trigger sample plus PEAK_WIN-1 non-falling samples
                    // exhaust the window; the latest sample is the peak.
                    if (r_win_cnt == WIN_W'(PEAK_WIN - 2)) begin
                        amp_n   = filt_data;
                        tmo_n   = 1'b1;
                        ho_n    = '0;
                        state_n = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (!en) begin
                    state_n = ST_IDLE;
                end else if (w_above) begin
                    // A new excursion after the signal had already settled
                    // is a second pulse riding on this one.
                    if (r_ho_cnt != '0) begin
                        pile_n = 1'b1;
                    end
                    ho_n = '0;
                end else begin
                    ho_n = w_ho_inc;
                    if (w_ho_inc == HO_W'(HOLDOFF)) begin
                        state_n = ST_EMIT;
                    end
                end
            end

            ST_EMIT: begin
                w_emit  = 1'b1;
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    assign w_load_rec = {r_amp, r_ts, r_pileup, r_timeout};

    event_out_reg #(
        .REC_W  (REC_W),
        .DROP_W (DROP_W)
    ) u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (w_emit),
        .load_rec (w_load_rec),
        .ready    (ev.ev_ready),
        .valid    (ev.ev_valid),
        .rec      (w_rec),
        .drop_cnt (drop_cnt)
    );

    assign ev.ev_amp     = w_rec[REC_W-1 -: DATA_W];
    assign ev.ev_ts      = w_rec[TS_W+1 -: TS_W];
    assign ev.ev_pileup  = w_rec[1];
    assign ev.ev_timeout = w_rec[0];

    assign busy = (r_state != ST_IDLE);

endmodule : pulse_event_ctrl
`default_nettype wire

// File: tb/tb_pulse_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_event_ctrl
//  Purpose  : Directed self-checking bench for pulse_event_ctrl with
//             threshold=100, HOLDOFF=4, PEAK_WIN=8.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_event_ctrl;

    localparam int DATA_W   = 21;
    localparam int TS_W     = 32;
    localparam int PEAK_WIN = 8;
    localparam int HOLDOFF  = 4;
    localparam int DROP_W   = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     en;
    logic signed [DATA_W-1:0] filt_data;
    logic signed [DATA_W-1:0] threshold;
    logic        [DROP_W-1:0] drop_cnt;
    logic                     busy;

    int tests = 0;
    int fails = 0;

    // Reference timestamp: counts clock edges since the last reset edge.
    logic [TS_W-1:0] cyc = '0;
    logic [TS_W-1:0] last_cyc;
    logic [TS_W-1:0] t_exp;

    pulse_event_ctrl_if #(.DATA_W(DATA_W), .TS_W(TS_W)) ev_if ();

    pulse_event_ctrl #(
        .DATA_W   (DATA_W),
        .TS_W     (TS_W),
        .PEAK_WIN (PEAK_WIN),
        .HOLDOFF  (HOLDOFF),
        .DROP_W   (DROP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .filt_data (filt_data),
        .threshold (threshold),
        .ev        (ev_if),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= (!reset) ? '0 : cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one sample, let one edge pass, settle 1 time unit.
    task automatic feed(input int v);
        filt_data = v;
        last_cyc  = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_n(input int v, input int n);
        for (int i = 0; i < n; i++) feed(v);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; filt_data = '0; threshold = 100;
        ev_if.ev_ready = 1'b1;
        feed_n(0, 3);
        chk("rst_valid",   ev_if.ev_valid,   0);
        chk("rst_amp",     ev_if.ev_amp,     0);
        chk("rst_ts",      ev_if.ev_ts,      0);
        chk("rst_flags",   {ev_if.ev_pileup, ev_if.ev_timeout}, 0);
        chk("rst_drop",    drop_cnt,         0);
        chk("rst_busy",    busy,             0);
        reset = 1'b1; en = 1'b1;
        feed_n(0, 2);

        // ---- single pulse
        feed(50);
        chk("sp_idle", busy, 0);
        feed(120); t_exp = last_cyc;
        chk("sp_busy", busy, 1);
        feed(300); feed(500); feed(400);
        feed_n(90, 3);
        chk("sp_not_yet", ev_if.ev_valid, 0);
        feed(90);
        chk("sp_emit_cycle", ev_if.ev_valid, 0);
        feed(0);
        chk("sp_valid",   ev_if.ev_valid,   1);
        chk("sp_amp",     ev_if.ev_amp,     500);
        chk("sp_ts",      ev_if.ev_ts,      t_exp);
        chk("sp_pileup",  ev_if.ev_pileup,  0);
        chk("sp_timeout", ev_if.ev_timeout, 0);
        chk("sp_idle2",   busy,             0);
        feed(0);
        chk("sp_accept",  ev_if.ev_valid,   0);

        // ---- pile-up
        feed(120); t_exp = last_cyc;
        feed(500); feed(300); feed(90); feed(90); feed(150);
        feed_n(90, 4);
        feed(0);
        chk("pu_valid",   ev_if.ev_valid,   1);
        chk("pu_amp",     ev_if.ev_amp,     500);
        chk("pu_ts",      ev_if.ev_ts,      t_exp);
        chk("pu_pileup",  ev_if.ev_pileup,  1);
        chk("pu_timeout", ev_if.ev_timeout, 0);
        feed_n(0, 6);
        chk("pu_no_second", ev_if.ev_valid, 0);
        chk("pu_idle",      busy,           0);

        // ---- peak search timeout
        for (int s = 110; s <= 180; s += 10) feed(s);
        chk("to_busy", busy, 1);
        feed_n(0, 4);
        chk("to_emit_cycle", ev_if.ev_valid, 0);
        feed(0);
        chk("to_valid",   ev_if.ev_valid,   1);
        chk("to_amp",     ev_if.ev_amp,     180);
        chk("to_timeout", ev_if.ev_timeout, 1);
        chk("to_pileup",  ev_if.ev_pileup,  0);
        feed(0);

        // ---- threshold edges
        feed_n(100, 3);
        chk("eq_no_trig", busy, 0);
        threshold = -50;
        feed(-40);
        chk("neg_trig", busy, 1);
        feed(-60);
        feed_n(-60, 4);
        feed(-60);
        chk("neg_valid", ev_if.ev_valid, 1);
        chk("neg_amp",   ev_if.ev_amp,   -40);
        feed(-60);
        threshold = 100;
        feed(0);

        // ---- back-pressure: three pulses, only the first is kept
        ev_if.ev_ready = 1'b0;
        feed(120); t_exp = last_cyc;
        feed(500); feed(300); feed_n(90, 4); feed(0);
        feed(120); feed(400); feed(300); feed_n(90, 4); feed(0);
        feed(120); feed(200); feed(90);  feed_n(90, 4); feed(0);
        chk("bp_valid", ev_if.ev_valid, 1);
        chk("bp_amp",   ev_if.ev_amp,   500);
        chk("bp_ts",    ev_if.ev_ts,    t_exp);
        chk("bp_drop",  drop_cnt,       2);
        ev_if.ev_ready = 1'b1;
        feed(0);
        chk("bp_release", ev_if.ev_valid, 0);
        chk("bp_drop2",   drop_cnt,       2);

        // ---- en dropped mid-RISE
        feed(120); feed(300);
        en = 1'b0;
        feed(400);
        chk("en_abort_idle", busy, 0);
        en = 1'b1;
        feed_n(0, 8);
        chk("en_abort_noev", ev_if.ev_valid, 0);
        chk("en_abort_drop", drop_cnt,       2);

        // ---- reset mid-HOLD
        feed(120); feed(500); feed(300); feed(90);
        chk("rh_busy", busy, 1);
        reset = 1'b0;
        feed(90);
        chk("rh_idle", busy,           0);
        chk("rh_drop", drop_cnt,       0);
        chk("rh_val",  ev_if.ev_valid, 0);
        reset = 1'b1;
        feed_n(90, 6);
        chk("rh_noev", ev_if.ev_valid, 0);

        // ---- timestamp restarts from reset
        reset = 1'b0; feed(0); reset = 1'b1;
        feed(0);
        feed(120); t_exp = last_cyc;
        feed(90); feed_n(90, 4); feed(0);
        chk("ts_valid", ev_if.ev_valid, 1);
        chk("ts_small", ev_if.ev_ts,    t_exp);
        chk("ts_amp",   ev_if.ev_amp,   120);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pulse_event_ctrl
`default_nettype wire
